mem_datos_ctrl: RTL
===================

Name: mem_datos_ctrl

Overview:
Access controller and arbiter in front of the ram_datos data memory (single-port, LOW_LATENCY: read data valid the cycle after enable).
- Serves two requesters: the MIPS MEM stage (CPU port) and the debug unit (DBG port, read-only memory dump).
- Converts byte addresses to word indices, extracts and extends sub-word loads, and performs byte/half stores as read-modify-write.
- Stalls the CPU while an access is pending.

Parameters:
- RAM_WIDTH, 32, data word width (fixed at 32 for lane logic).
- ADDR_W, 11, RAM word-index width (2048 words).
- STARVE_LIMIT, 16, number of consecutive denied DBG cycles before DBG is forced a grant.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_cpu_req  in  1  CPU access request; level, held with operands while o_cpu_stall=1.
- i_cpu_we  in  1  1=store, 0=load.
- i_cpu_size  in  2  00 byte, 01 half, 10 word (11 treated as word).
- i_cpu_unsigned  in  1  zero-extend loads (LBU/LHU).
- i_cpu_addr  in  32  byte address.
- i_cpu_wdata  in  32  store data, right-aligned.
- o_cpu_rdata  out  32  load result, meaningful only when o_cpu_valid=1, else 0.
- o_cpu_valid  out  1  access completes this cycle.
- o_cpu_stall  out  1  request pending, not completing this cycle.
- o_cpu_misaligned  out  1  pulse: misaligned access rejected.
- i_dbg_req  in  1  debug read request; level.
- i_dbg_addr  in  ADDR_W  word index.
- o_dbg_rdata  out  32  registered; holds last debug read.
- o_dbg_valid  out  1  registered one-cycle pulse, o_dbg_rdata updated.
- o_ram_addr  out  ADDR_W  to ram_datos i_addra.
- o_ram_din  out  32  to i_dina.
- o_ram_we  out  1  to i_wea.
- o_ram_en  out  1  to i_ena.
- i_ram_dout  in  32  from o_douta.

Behaviour:
- States: IDLE, CPU_RD, CPU_RMW, DBG_RD. Reset: IDLE, starve counter 0, o_dbg_rdata 0, o_dbg_valid 0.
- Combinational outputs o_ram_*, o_cpu_* are 0 in IDLE with no request.
- Word index = i_cpu_addr[ADDR_W+1:2]; upper bits ignored (wrap).
- Misalignment: half with addr[0]=1, or word with addr[1:0]≠0.
  - In IDLE: no RAM access, o_cpu_misaligned=1, o_cpu_valid=1, stall=0, rdata=0.
- Grant, IDLE only. CPU has priority unless starve counter == STARVE_LIMIT, in which case DBG wins.
  - Counter increments each cycle i_dbg_req=1 and DBG is not granted; saturates at STARVE_LIMIT; cleared on DBG grant.
- CPU word store: en=1, we=1, din=wdata in IDLE; valid=1, stall=0 same cycle; stay IDLE.
- CPU load: IDLE issues en=1 with stall=1 -> CPU_RD. In CPU_RD: lane select, little-endian.
  - byte lane = addr[1:0] (lane0 = bits 7:0); half lane = addr[1].
  - Sign or zero extend per i_cpu_unsigned; valid=1, stall=0 -> IDLE.
- CPU byte/half store: IDLE issues read (en=1, we=0, stall=1) -> CPU_RMW.
  - CPU_RMW: din = i_ram_dout with the addressed lane replaced by the low bits of wdata; en=1, we=1, valid=1, stall=0 -> IDLE.
- DBG read: IDLE issues en=1 at i_dbg_addr -> DBG_RD.
  - DBG_RD: o_dbg_rdata<=i_ram_dout, o_dbg_valid<=1 (visible next cycle) -> IDLE.
  - CPU stall=1 if i_cpu_req during any DBG cycle.
- A held request is re-served each completion; back-to-back loads take 2 cycles each.
- Reset mid-operation: immediate return to IDLE. A pending RMW write is abandoned (RAM unchanged). No valid pulses.

Decomposition:
- Shared package mips_mem_pkg:
  - size codes SZ_BYTE/SZ_HALF/SZ_WORD
  - state encoding
  - lane-merge and load-extend functions
- One natural sub-module: mem_lane_fmt, a combinational load extend and store merge, reusable by a later pipelined MEM stage.

Test Plan:
- Word store 0xDEADBEEF @0x10, then word load @0x10 -> store valid in 1 cycle, stall=0; load stall 1 cycle, then rdata=0xDEADBEEF.
- SB 0x7F @0x11 over word 0xDEADBEEF at 0x10, then LW -> 0xDEAD7FEF. LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE.
- SH 0x1234 @0x12, then LHU @0x12 -> 0x00001234. LH @0x12 after SH 0x8001 -> 0xFFFF8001.
- LW @0x06 -> o_cpu_misaligned=1, valid=1, rdata=0, o_ram_en never asserted.
- CPU loads continuously while i_dbg_req=1 at index 4 -> DBG granted after exactly 16 denied cycles, o_dbg_valid one cycle after DBG_RD, CPU stalled during DBG, counter back to 0.
- Assert i_reset during CPU_RMW for SB @0x20 -> state IDLE, memory word at 0x20 unchanged, no valid pulse.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared MEM-stage types, size codes and lane helpers
//
// Purpose: size codes, controller state encoding and the little-endian
// load-extend / store-merge functions used by the data-memory path.
// Ports: none (package).
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_CPU_RD  = 2'b01,
    ST_CPU_RMW = 2'b10,
    ST_DBG_RD  = 2'b11
  } mem_state_t;

  // Pull the addressed lane down to bit 0 and sign/zero extend it.
  // Size code 11 falls through to the full-word case.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane,
                                              input logic        is_unsigned);
    logic [31:0] shifted;
    logic [31:0] result;
    result = word;
    if (size == SZ_BYTE) begin
      shifted = word >> {lane, 3'b000};
      result  = {{24{shifted[7] & ~is_unsigned}}, shifted[7:0]};
    end else if (size == SZ_HALF) begin
      shifted = word >> {lane[1], 4'b0000};
      result  = {{16{shifted[15] & ~is_unsigned}}, shifted[15:0]};
    end
    return result;
  endfunction

  // Replace the addressed lane of the old word with the low bits of wdata.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                             input logic [31:0] wdata,
                                             input logic [1:0]  size,
                                             input logic [1:0]  lane);
    logic [4:0]  sh;
    logic [31:0] mask;
    logic [31:0] result;
    result = wdata;
    if (size == SZ_BYTE) begin
      sh     = {lane, 3'b000};
      mask   = 32'h0000_00FF << sh;
      result = (old_word & ~mask) | ((wdata << sh) & mask);
    end else if (size == SZ_HALF) begin
      sh     = {lane[1], 4'b0000};
      mask   = 32'h0000_FFFF << sh;
      result = (old_word & ~mask) | ((wdata << sh) & mask);
    end
    return result;
  endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// rtl/mem_lane_fmt.sv - combinational load extend and store merge
//
// Purpose: formats a RAM word for sub-word loads and builds the write word
// for byte/half stores. Purely combinational.
// Ports:
//   ram_word    in  32  word read from memory
//   wdata       in  32  right-aligned store data
//   size        in  2   size code (byte/half/word, 11 = word)
//   lane        in  2   byte address bits [1:0]
//   is_unsigned in  1   zero-extend loads
//   load_data   out 32  extended load result
//   store_word  out 32  old word with addressed lane replaced
module mem_lane_fmt
  import mips_mem_pkg::*;
(
  input  logic [31:0] ram_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        is_unsigned,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  assign load_data  = load_extend(ram_word, size, lane, is_unsigned);
  assign store_word = lane_merge(ram_word, wdata, size, lane);

endmodule

// File: rtl/mem_datos_ctrl.sv
// rtl/mem_datos_ctrl.sv - ram_datos access controller and CPU/debug arbiter
//
// Purpose: arbitrates the single-port data RAM between the CPU MEM stage and
// the debug dump port, converts byte addresses to word indices, formats
// sub-word loads and performs byte/half stores as read-modify-write.
// Ports:
//   i_clk, i_reset                  clock, async active-high reset
//   i_cpu_* / o_cpu_*               CPU request, result, stall, misalign pulse
//   i_dbg_req, i_dbg_addr           debug word-read request
//   o_dbg_rdata, o_dbg_valid        registered debug result and pulse
//   o_ram_*, i_ram_dout             ram_datos port (read data one cycle later)
module mem_datos_ctrl
  import mips_mem_pkg::*;
#(
  parameter int RAM_WIDTH    = 32,
  parameter int ADDR_W       = 11,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_cpu_req,
  input  logic                 i_cpu_we,
  input  logic [1:0]           i_cpu_size,
  input  logic                 i_cpu_unsigned,
  input  logic [31:0]          i_cpu_addr,
  input  logic [RAM_WIDTH-1:0] i_cpu_wdata,
  output logic [RAM_WIDTH-1:0] o_cpu_rdata,
  output logic                 o_cpu_valid,
  output logic                 o_cpu_stall,
  output logic                 o_cpu_misaligned,
  input  logic                 i_dbg_req,
  input  logic [ADDR_W-1:0]    i_dbg_addr,
  output logic [RAM_WIDTH-1:0] o_dbg_rdata,
  output logic                 o_dbg_valid,
  output logic [ADDR_W-1:0]    o_ram_addr,
  output logic [RAM_WIDTH-1:0] o_ram_din,
  output logic                 o_ram_we,
  output logic                 o_ram_en,
  input  logic [RAM_WIDTH-1:0] i_ram_dout
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

  mem_state_t          state;
  mem_state_t          state_next;
  logic [CW-1:0]       starve_cnt;
  logic                starve_full;
  logic                dbg_wins;
  logic                dbg_grant;
  logic [ADDR_W-1:0]   cpu_idx;
  logic                cpu_is_word;
  logic                cpu_misaligned;
  logic [31:0]         load_data;
  logic [31:0]         store_word;
  logic                unused_addr_hi;

  // Upper address bits are ignored so the address space wraps.
  assign cpu_idx        = i_cpu_addr[ADDR_W+1:2];
  assign unused_addr_hi = ^i_cpu_addr[31:ADDR_W+2];
  assign cpu_is_word    = i_cpu_size[1];
  assign cpu_misaligned = ((i_cpu_size == SZ_HALF) && i_cpu_addr[0]) ||
                          (cpu_is_word && (i_cpu_addr[1:0] != 2'b00));

  assign starve_full = (starve_cnt == STARVE_MAX);
  // CPU normally wins; a debug requester starved long enough takes the slot.
  assign dbg_wins    = i_dbg_req && (!i_cpu_req || starve_full);

  mem_lane_fmt u_lane_fmt (
    .ram_word    (i_ram_dout),
    .wdata       (i_cpu_wdata),
    .size        (i_cpu_size),
    .lane        (i_cpu_addr[1:0]),
    .is_unsigned (i_cpu_unsigned),
    .load_data   (load_data),
    .store_word  (store_word)
  );

  always_comb begin
    state_next       = state;
    o_ram_addr       = '0;
    o_ram_din        = '0;
    o_ram_we         = 1'b0;
    o_ram_en         = 1'b0;
    o_cpu_rdata      = '0;
    o_cpu_valid      = 1'b0;
    o_cpu_stall      = 1'b0;
    o_cpu_misaligned = 1'b0;
    dbg_grant        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (dbg_wins) begin
          dbg_grant   = 1'b1;
          o_ram_en    = 1'b1;
          o_ram_addr  = i_dbg_addr;
          o_cpu_stall = i_cpu_req;
          state_next  = ST_DBG_RD;
        end else if (i_cpu_req) begin
          if (cpu_misaligned) begin
            o_cpu_misaligned = 1'b1;
            o_cpu_valid      = 1'b1;
          end else if (i_cpu_we && cpu_is_word) begin
            // Full-word store needs no read, completes in one cycle.
            o_ram_en    = 1'b1;
            o_ram_we    = 1'b1;
            o_ram_addr  = cpu_idx;
            o_ram_din   = i_cpu_wdata;
            o_cpu_valid = 1'b1;
          end else begin
            // Loads and sub-word stores both start with a read.
            o_ram_en    = 1'b1;
            o_ram_addr  = cpu_idx;
            o_cpu_stall = 1'b1;
            state_next  = i_cpu_we ? ST_CPU_RMW : ST_CPU_RD;
          end
        end
      end
      ST_CPU_RD: begin
        o_cpu_rdata = load_data;
        o_cpu_valid = 1'b1;
        state_next  = ST_IDLE;
      end
      ST_CPU_RMW: begin
        o_ram_en    = 1'b1;
        o_ram_we    = 1'b1;
        o_ram_addr  = cpu_idx;
        o_ram_din   = store_word;
        o_cpu_valid = 1'b1;
        state_next  = ST_IDLE;
      end
      ST_DBG_RD: begin
        o_cpu_stall = i_cpu_req;
        state_next  = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= ST_IDLE;
      starve_cnt  <= '0;
      o_dbg_rdata <= '0;
      o_dbg_valid <= 1'b0;
    end else begin
      state       <= state_next;
      o_dbg_valid <= 1'b0;
      if (state == ST_DBG_RD) begin
        o_dbg_rdata <= i_ram_dout;
        o_dbg_valid <= 1'b1;
      end
      // The debug read cycle itself is service, not denial.
      if (dbg_grant) begin
        starve_cnt <= '0;
      end else if (i_dbg_req && (state != ST_DBG_RD) && !starve_full) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule
